// File: rtl/noc_pkg.sv
// Shared NoC endpoint definitions: address width, packet field positions,
// LFSR polynomial and the Tx/Rx handshake state encodings.
package noc_pkg;

    localparam int POS_W = 4;

    // Fibonacci taps for x^8+x^6+x^5+x^4+1 (state bits 7,5,4,3)
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    typedef enum logic [1:0] {
        TX_IDLE         = 2'd0,
        TX_REQ          = 2'd1,
        TX_WAIT_ACK_LOW = 2'd2
    } tx_state_e;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_ACK  = 1'b1
    } rx_state_e;

    function automatic int pkt_dst_msb(input int dw);
        return dw - 1;
    endfunction

    function automatic int pkt_src_msb(input int dw);
        return dw - 1 - POS_W;
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

    // An all-zero seed would lock the LFSR, so it is nudged to 1
    function automatic logic [7:0] lfsr_seed(input logic [POS_W-1:0] pos);
        logic [7:0] s;
        s = {pos, pos ^ 4'hA};
        if (s == 8'h00) begin
            s = 8'h01;
        end else begin
            s = s;
        end
        return s;
    endfunction

endpackage

// File: rtl/ip_rx_sink.sv
// Packet consumer: 4-phase Rx handshake, receive counter and sticky
// misrouted-packet flag.
module ip_rx_sink
    import noc_pkg::*;
#(
    parameter logic [POS_W-1:0] POSITION = 4'b0101
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             inr,
    input  logic [POS_W-1:0] dst,
    output logic             inw,
    output logic [15:0]      rx_count,
    output logic             rx_err
);

    rx_state_e   state_r, state_s;
    logic        inw_r, inw_s;
    logic [15:0] rx_count_r, rx_count_s;
    logic        rx_err_r, rx_err_s;

    // Next-state logic; a request is only accepted from IDLE so a held Inr counts once
    always_comb begin
        state_s    = state_r;
        inw_s      = inw_r;
        rx_count_s = rx_count_r;
        rx_err_s   = rx_err_r;
        case (state_r)
            RX_IDLE: begin
                if (inr) begin
                    state_s    = RX_ACK;
                    inw_s      = 1'b1;
                    rx_count_s = rx_count_r + 16'd1;
                    if (dst != POSITION) begin
                        rx_err_s = 1'b1;
                    end else begin
                        rx_err_s = rx_err_r;
                    end
                end else begin
                    state_s = RX_IDLE;
                end
            end
            RX_ACK: begin
                if (!inr) begin
                    state_s = RX_IDLE;
                    inw_s   = 1'b0;
                end else begin
                    state_s = RX_ACK;
                end
            end
            default: begin
                state_s = RX_IDLE;
                inw_s   = 1'b0;
            end
        endcase
    end

    // Rx state and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= RX_IDLE;
            inw_r      <= 1'b0;
            rx_count_r <= 16'd0;
            rx_err_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            inw_r      <= inw_s;
            rx_count_r <= rx_count_s;
            rx_err_r   <= rx_err_s;
        end
    end

    assign inw      = inw_r;
    assign rx_count = rx_count_r;
    assign rx_err   = rx_err_r;

endmodule

// File: rtl/ip_tx_gen.sv
// Packet producer: free-running injection period counter, destination LFSR
// and the 4-phase request/acknowledge Tx state machine.
module ip_tx_gen
    import noc_pkg::*;
#(
    parameter int                DATA_WIDTH = 37,
    parameter logic [POS_W-1:0]  POSITION   = 4'b0101,
    parameter int                FREQ       = 4
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  outw,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  outr,
    output logic [15:0]           tx_count
);

    localparam int               CNT_W     = $clog2(FREQ);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FREQ - 1);
    localparam int               SEQ_W     = DATA_WIDTH - 2 * POS_W;
    localparam logic [7:0]       LFSR_SEED = lfsr_seed(POSITION);

    logic [CNT_W-1:0]      cnt_r;
    tx_state_e             state_r, state_s;
    logic                  outr_r, outr_s;
    logic [DATA_WIDTH-1:0] data_r, data_s;
    logic [SEQ_W-1:0]      seq_r, seq_s;
    logic [7:0]            lfsr_r, lfsr_s;
    logic [15:0]           tx_count_r, tx_count_s;
    logic [POS_W-1:0]      dst_s;
    logic                  tick_s;
    logic                  load_s;

    // Injection period counter, wraps every FREQ cycles regardless of Tx state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Next-state logic; a slot that finds Tx busy or ack still high is dropped
    always_comb begin
        tick_s     = (cnt_r == CNT_LAST);
        state_s    = state_r;
        outr_s     = outr_r;
        data_s     = data_r;
        seq_s      = seq_r;
        lfsr_s     = lfsr_r;
        tx_count_s = tx_count_r;
        load_s     = 1'b0;
        if (lfsr_r[POS_W-1:0] == POSITION) begin
            dst_s = lfsr_r[POS_W-1:0] ^ 4'b0001;
        end else begin
            dst_s = lfsr_r[POS_W-1:0];
        end
        case (state_r)
            TX_IDLE: begin
                if (tick_s && !outw) begin
                    load_s = 1'b1;
                end else begin
                    state_s = TX_IDLE;
                end
            end
            TX_REQ: begin
                if (outw) begin
                    state_s    = TX_WAIT_ACK_LOW;
                    outr_s     = 1'b0;
                    seq_s      = seq_r + SEQ_W'(1);
                    tx_count_s = tx_count_r + 16'd1;
                end else begin
                    state_s = TX_REQ;
                end
            end
            TX_WAIT_ACK_LOW: begin
                // Ack release and a slot tick on the same edge still injects
                if (outw) begin
                    state_s = TX_WAIT_ACK_LOW;
                end else if (tick_s) begin
                    load_s = 1'b1;
                end else begin
                    state_s = TX_IDLE;
                end
            end
            default: begin
                state_s = TX_IDLE;
                outr_s  = 1'b0;
            end
        endcase
        if (load_s) begin
            state_s = TX_REQ;
            outr_s  = 1'b1;
            data_s  = {dst_s, POSITION, seq_r};
            lfsr_s  = lfsr_next(lfsr_r);
        end else begin
            lfsr_s = lfsr_r;
        end
    end

    // Tx state and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= TX_IDLE;
            outr_r     <= 1'b0;
            data_r     <= '0;
            seq_r      <= '0;
            lfsr_r     <= LFSR_SEED;
            tx_count_r <= 16'd0;
        end else begin
            state_r    <= state_s;
            outr_r     <= outr_s;
            data_r     <= data_s;
            seq_r      <= seq_s;
            lfsr_r     <= lfsr_s;
            tx_count_r <= tx_count_s;
        end
    end

    assign data_out = data_r;
    assign outr     = outr_r;
    assign tx_count = tx_count_r;

endmodule

// File: rtl/ip_traffic_endpoint.sv
// NoC tile endpoint: wires the packet producer and packet consumer to one
// router local port.
module ip_traffic_endpoint
    import noc_pkg::*;
#(
    parameter int               DATA_WIDTH = 37,
    parameter logic [POS_W-1:0] POSITION   = 4'b0101,
    parameter int               FREQ       = 4
)(
    input  logic                  clk,
    input  logic                  reset,
    output logic [DATA_WIDTH-1:0] DataOutIP,
    output logic                  Outr,
    input  logic                  Outw,
    input  logic [DATA_WIDTH-1:0] DataInIP,
    input  logic                  Inr,
    output logic                  Inw,
    output logic [15:0]           tx_count,
    output logic [15:0]           rx_count,
    output logic                  rx_err
);

    localparam int DST_MSB = pkt_dst_msb(DATA_WIDTH);

    ip_tx_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .POSITION   (POSITION),
        .FREQ       (FREQ)
    ) u_tx (
        .clk      (clk),
        .reset    (reset),
        .outw     (Outw),
        .data_out (DataOutIP),
        .outr     (Outr),
        .tx_count (tx_count)
    );

    ip_rx_sink #(
        .POSITION (POSITION)
    ) u_rx (
        .clk      (clk),
        .reset    (reset),
        .inr      (Inr),
        .dst      (DataInIP[DST_MSB -: POS_W]),
        .inw      (Inw),
        .rx_count (rx_count),
        .rx_err   (rx_err)
    );

endmodule

// File: tb/tb_ip_traffic_endpoint.sv
// Directed self-checking bench for ip_traffic_endpoint (DATA_WIDTH=37,
// POSITION=4'b0101, FREQ=4).
module tb_ip_traffic_endpoint;

    localparam int         DW  = 37;
    localparam logic [3:0] POS = 4'b0101;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] DataOutIP;
    logic          Outr;
    logic          Outw;
    logic [DW-1:0] DataInIP;
    logic          Inr;
    logic          Inw;
    logic [15:0]   tx_count;
    logic [15:0]   rx_count;
    logic          rx_err;

    int n_tests = 0;
    int n_fail  = 0;

    // bench-side model of the producer
    logic [7:0]    lfsr_m;
    logic [28:0]   exp_seq;
    logic [3:0]    exp_dst;
    logic [DW-1:0] exp_pkt;
    logic          outr_prev;
    logic          auto_ack;
    logic          chk_len;
    int            hi_len;
    int            n_pkts;
    int            n_done;
    int            done_before;

    ip_traffic_endpoint #(.DATA_WIDTH(DW), .POSITION(POS), .FREQ(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .DataOutIP (DataOutIP),
        .Outr      (Outr),
        .Outw      (Outw),
        .DataInIP  (DataInIP),
        .Inr       (Inr),
        .Inw       (Inw),
        .tx_count  (tx_count),
        .rx_count  (rx_count),
        .rx_err    (rx_err)
    );

    always #5 clk = ~clk;

    always @(posedge reset) $display("[TB] reset asserted, POSITION=%b", POS);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        lfsr_m    = 8'h5F;
        exp_seq   = 29'd0;
        outr_prev = 1'b0;
        hi_len    = 0;
        n_done    = 0;
    endtask

    // One clock: sample at the falling edge, check each new packet, drive Outw
    task automatic cyc();
        @(negedge clk);
        if (Outr && !outr_prev) begin
            exp_dst = lfsr_m[3:0];
            if (exp_dst == POS) exp_dst = exp_dst ^ 4'b0001;
            exp_pkt = {exp_dst, POS, exp_seq};
            chk("pkt", DataOutIP, exp_pkt);
            chk("dst_not_own", 64'(DataOutIP[36:33] == POS), 64'd0);
            lfsr_m  = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
            exp_seq = exp_seq + 29'd1;
            n_pkts++;
        end
        if (Outr) begin
            hi_len++;
        end else begin
            if (outr_prev && chk_len) chk("outr_len", 64'(hi_len), 64'd2);
            if (outr_prev) n_done++;
            hi_len = 0;
        end
        if (auto_ack) Outw = outr_prev;
        outr_prev = Outr;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_outr", 64'(Outr), 64'd0);
        chk("rst_inw", 64'(Inw), 64'd0);
        chk("rst_data", 64'(DataOutIP), 64'd0);
        chk("rst_txcnt", 64'(tx_count), 64'd0);
        chk("rst_rxcnt", 64'(rx_count), 64'd0);
        chk("rst_rxerr", 64'(rx_err), 64'd0);
    endtask

    initial begin
        reset    = 1'b1;
        Outw     = 1'b0;
        Inr      = 1'b0;
        DataInIP = '0;
        auto_ack = 1'b1;
        chk_len  = 1'b1;
        n_pkts   = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_reset_outputs();
        reset = 1'b0;

        // first request appears on the 4th edge after release
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk("first_outr", 64'(Outr), (i == 4) ? 64'd1 : 64'd0);
        end
        chk("first_pkt", 64'(DataOutIP), {27'd0, 4'hF, 4'h5, 29'd0});

        // delayed ack: one packet per slot, 10 completions by edge 42
        repeat (38) cyc();
        chk("txcnt_10", 64'(tx_count), 64'd10);
        chk("pkts_10", 64'(n_pkts), 64'd10);

        // ack held low: request and data stay, slots dropped
        repeat (2) cyc();
        chk("stall_start", 64'(Outr), 64'd1);
        chk_len  = 1'b0;
        auto_ack = 1'b0;
        Outw     = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            chk("stall_outr", 64'(Outr), 64'd1);
            chk("stall_data", 64'(DataOutIP), 64'(exp_pkt));
        end
        chk("stall_txcnt", 64'(tx_count), 64'd10);
        auto_ack = 1'b1;

        // long run: 200 packets, sequence and destinations checked per packet
        for (int i = 0; i < 1500 && n_pkts < 200; i++) cyc();
        chk("pkts_200", 64'(n_pkts >= 200), 64'd1);

        // Rx: held request accepted once, correct destination
        done_before = n_done;
        DataInIP = {4'b0101, 4'h9, 29'h123};
        Inr      = 1'b1;
        cyc();
        chk("inw_rise", 64'(Inw), 64'd1);
        chk("rxcnt_1", 64'(rx_count), 64'd1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("inw_hold", 64'(Inw), 64'd1);
            chk("rxcnt_hold", 64'(rx_count), 64'd1);
        end
        Inr = 1'b0;
        cyc();
        chk("inw_fall", 64'(Inw), 64'd0);
        chk("rxerr_0", 64'(rx_err), 64'd0);
        chk("rxcnt_final", 64'(rx_count), 64'd1);

        // Rx: misrouted packet sets the sticky error
        DataInIP = {4'b0011, 4'h6, 29'h0ABC};
        Inr      = 1'b1;
        cyc();
        chk("bad_inw", 64'(Inw), 64'd1);
        chk("bad_rxcnt", 64'(rx_count), 64'd2);
        chk("bad_rxerr", 64'(rx_err), 64'd1);
        Inr = 1'b0;
        cyc();
        chk("bad_inw_fall", 64'(Inw), 64'd0);
        repeat (8) cyc();
        chk("rxerr_sticky", 64'(rx_err), 64'd1);
        chk("tx_during_rx", 64'(n_done > done_before), 64'd1);
        chk("txcnt_match", 64'(tx_count), 64'(n_done[15:0]));

        // reset mid-run: outputs clear at once, injection restarts from seed
        #2;
        reset = 1'b1;
        Outw  = 1'b0;
        #1;
        chk_reset_outputs();
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk("rst_outr_rise", 64'(Outr), (i == 4) ? 64'd1 : 64'd0);
        end
        chk("rst_first_pkt", 64'(DataOutIP), {27'd0, 4'hF, 4'h5, 29'd0});
        repeat (4) cyc();
        chk("rst_txcnt_1", 64'(tx_count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
